// File: rtl/blink_playback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : blink_playback_arbiter
// Description : Round-robin arbiter that shares one LED pin between NUM_REQ
//               requesters. The winner's pattern is latched into a shadow
//               register and played LSB first, one bit per TICK_RATE cycles,
//               followed by a one-cycle ack to the owner.
//               Optional feature macro: BLINK_ARB_ABORT_EN (adds abort input).
// Revision    : 1.0 - initial release
// ============================================================================
module blink_playback_arbiter #(
    parameter int  NUM_REQ       = 2,
    parameter int  PATTERN_WIDTH = 102,
    parameter int  TICK_RATE     = 5_000_000,
    localparam int IDXW          = $clog2(PATTERN_WIDTH + 1)
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*PATTERN_WIDTH-1:0] pattern,
    input  logic [NUM_REQ*IDXW-1:0]          length,
`ifdef BLINK_ARB_ABORT_EN
    input  logic                             abort,
`endif
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             busy,
    output logic                             LED,
    output logic [IDXW-1:0]                  blink_index
);

    localparam int              PTRW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW-1:0] C_MAX_LEN   = IDXW'(PATTERN_WIDTH);
    localparam logic [IDXW-1:0] C_IDX_ONE   = IDXW'(1);
    localparam logic [31:0]     C_TICK_LAST = 32'(TICK_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [PTRW-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic                     busy_q, busy_d;
    logic                     led_q, led_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [IDXW-1:0]          len_q, len_d;
    logic [31:0]              tick_q, tick_d;
    logic [PATTERN_WIDTH-1:0] shadow_q, shadow_d;
    logic [PATTERN_WIDTH-1:0] play_bits;

    logic                     rr_found;
    logic [PTRW-1:0]          rr_pick;
    int                       rr_cand;
    logic                     abort_hit;

    // Per-requester views of the flat pattern/length buses
    logic [PATTERN_WIDTH-1:0] slot_pat [NUM_REQ];
    logic [IDXW-1:0]          slot_len [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot_pat[g] = pattern[g*PATTERN_WIDTH +: PATTERN_WIDTH];
        assign slot_len[g] = length[g*IDXW +: IDXW];
    end

`ifdef BLINK_ARB_ABORT_EN
    assign abort_hit = abort && ((state_q == S_LOAD) || (state_q == S_PLAY));
`else
    assign abort_hit = 1'b0;
`endif

    // Round-robin pick: first set request after the last-served index, wrapping
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = ptr_q;
        rr_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!rr_found && req[PTRW'(rr_cand)]) begin
                rr_found = 1'b1;
                rr_pick  = PTRW'(rr_cand);
            end
        end
    end

    // Next-state logic: IDLE -> LOAD -> PLAY -> DONE -> IDLE
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        len_d    = len_q;
        tick_d   = tick_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                idx_d  = '0;
                tick_d = '0;
                if (rr_found) begin
                    ptr_d   = rr_pick;
                    grant_d = NUM_REQ'(1) << rr_pick;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shadow_d = slot_pat[ptr_q];
                len_d    = (slot_len[ptr_q] > C_MAX_LEN) ? C_MAX_LEN : slot_len[ptr_q];
                idx_d    = '0;
                tick_d   = '0;
                state_d  = (len_d == '0) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
                if (tick_q == C_TICK_LAST) begin
                    tick_d = '0;
                    // Last bit finished: leave idx on it rather than wrapping
                    if (idx_q == len_q - C_IDX_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + C_IDX_ONE;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_DONE;
        end
    end

    // Registered outputs derived from the upcoming state so the pin never glitches
    always_comb begin
        play_bits = shadow_d >> idx_d;
        led_d     = (state_d == S_PLAY) ? play_bits[0] : 1'b0;
        ack_d     = (state_d == S_DONE) ? grant_d : '0;
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            ptr_q    <= PTRW'(NUM_REQ - 1);
            grant_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            tick_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            tick_q   <= tick_d;
            shadow_q <= shadow_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign LED         = led_q;
    assign blink_index = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_playback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_playback_arbiter
// Description : Self-checking bench for blink_playback_arbiter with
//               NUM_REQ=2, PATTERN_WIDTH=8, TICK_RATE=4. Table vectors,
//               directed corner sequences and random traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_playback_arbiter;

    localparam int NR = 2;
    localparam int PW = 8;
    localparam int TR = 4;
    localparam int IW = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [1:0]    req    = '0;
    logic [15:0]   pattern = '0;
    logic [7:0]    length = '0;
    logic          abort  = 1'b0;
    logic [1:0]    grant;
    logic [1:0]    ack;
    logic          busy;
    logic          led;
    logic [3:0]    bidx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blink_playback_arbiter #(
        .NUM_REQ       (NR),
        .PATTERN_WIDTH (PW),
        .TICK_RATE     (TR)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .req         (req),
        .pattern     (pattern),
        .length      (length),
`ifdef BLINK_ARB_ABORT_EN
        .abort       (abort),
`endif
        .grant       (grant),
        .ack         (ack),
        .busy        (busy),
        .LED         (led),
        .blink_index (bidx)
    );

    // Reference model: one transaction at a time, tracked as a cycle offset
    // n from the grant cycle (n=0) to the ack cycle (n=m_d).
    bit         m_act   = 1'b0;
    int         m_n     = 0;
    int         m_owner = 0;
    int         m_len   = 0;
    int         m_d     = 1;
    int         m_ptr   = NR - 1;
    logic [7:0] m_pat   = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_act = 1'b0;
            m_ptr = NR - 1;
        end else if (m_act) begin
            if (m_n == 0) begin
                m_pat = pattern[m_owner*PW +: PW];
                m_len = int'(length[m_owner*IW +: IW]);
                if (m_len > PW) m_len = PW;
                m_d = (m_len == 0) ? 1 : 1 + m_len * TR;
            end
            if (abort && m_n < m_d) m_d = m_n + 1;
            if (m_n == m_d) m_act = 1'b0;
            else m_n++;
        end else if (req != 2'b00) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_ptr = m_owner;
            m_act = 1'b1;
            m_n   = 0;
        end
    endtask

    task automatic model_compare();
        int eg, ea, el, ei, eb;
        bit chk_i;
        eg = 0; ea = 0; el = 0; ei = 0; eb = 0; chk_i = 1'b1;
        if (m_act) begin
            eg = 1 << m_owner;
            eb = 1;
            if (m_n != 0) begin
                if (m_n == m_d) begin
                    ea    = eg;
                    chk_i = 1'b0;
                end else begin
                    ei = (m_n - 1) / TR;
                    el = int'(m_pat[ei]);
                end
            end
        end
        check("model_grant", int'(grant), eg);
        check("model_ack", int'(ack), ea);
        check("model_busy", int'(busy), eb);
        check("model_led", int'(led), el);
        if (chk_i) check("model_blink_index", int'(bidx), ei);
    endtask

    // Inputs are changed at the falling edge; outputs are sampled there too
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_compare();
    endtask

    task automatic go_idle();
        req = 2'b00;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            step();
        end
        check("go_idle_timeout", int'(busy), 0);
    endtask

    typedef struct packed {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] g;
        logic [1:0] a;
        logic       b;
        logic       l;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [1:0] gq [$];
        logic [1:0] prev_g;
        int         busy_cnt;

        // Reset then slot0 = 101 (len 3), slot1 = len 0
        tbl[0]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0};
        for (int i = 3; i <= 14; i++)
            tbl[i] = '{1'b1, 2'b00, 2'b01, 2'b00, 1'b1, ((i - 3) / 4 != 1)};
        tbl[15] = '{1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

        pattern = 16'h0005;
        length  = {4'd0, 4'd3};
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            step();
            check($sformatf("tbl%0d_grant", i), int'(grant), int'(tbl[i].g));
            check($sformatf("tbl%0d_ack", i), int'(ack), int'(tbl[i].a));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].b));
            check($sformatf("tbl%0d_led", i), int'(led), int'(tbl[i].l));
        end

        // Fairness: both requesting continuously, len 2 each
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        req     = 2'b11;
        pattern = 16'hA5C3;
        length  = {4'd2, 4'd2};
        prev_g  = 2'b00;
        for (int i = 0; i < 100; i++) begin
            step();
            if (grant != 2'b00 && prev_g == 2'b00) gq.push_back(grant);
            prev_g = grant;
            if (gq.size() == 4) break;
        end
        check("rr_grant_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("rr_grant%0d", i), int'(gq[i]), (i % 2 == 0) ? 1 : 2);
        go_idle();

        // Length above PATTERN_WIDTH is clamped: 1 LOAD + 32 PLAY + 1 DONE
        pattern  = 16'h00A5;
        length   = {4'd0, 4'd12};
        req      = 2'b01;
        step();
        req      = 2'b00;
        busy_cnt = int'(busy);
        for (int i = 0; i < 60; i++) begin
            step();
            if (!busy) break;
            busy_cnt++;
        end
        check("clamp_busy_cycles", busy_cnt, 34);

        // Reset in the middle of playback, then requester 1 alone
        go_idle();
        pattern = 16'h0006;
        length  = {4'd0, 4'd3};
        req     = 2'b01;
        step();
        req = 2'b10;
        for (int i = 0; i < 5; i++) step();
        check("midplay_index", int'(bidx), 1);
        rst_n = 1'b0;
        step();
        check("rst_grant", int'(grant), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_grant", int'(grant), 2);
        go_idle();

`ifdef BLINK_ARB_ABORT_EN
        // Abort while playing bit 2
        pattern = 16'h00FF;
        length  = {4'd0, 4'd8};
        req     = 2'b01;
        step();
        req = 2'b00;
        for (int i = 0; i < 9; i++) step();
        check("abort_pre_index", int'(bidx), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ack", int'(ack), 1);
        check("abort_led", int'(led), 0);
        step();
        check("abort_busy_after", int'(busy), 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            req     = 2'($urandom);
            pattern = 16'($urandom);
            length  = 8'($urandom);
`ifdef BLINK_ARB_ABORT_EN
            abort   = ($urandom_range(0, 49) == 0);
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
